// File: rtl/uart_rx_unit_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and default baud constants.
// Also used by the TX unit through baud_tick_gen.
package uart_rx_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } rx_state_e;

  // 19200 baud from a 50 MHz clock with 16x oversampling
  localparam int unsigned DVSR_DEFAULT     = 163;
  localparam int unsigned DVSR_BIT_DEFAULT = 8;
  localparam int unsigned N_TICK_DEFAULT   = 16;
  localparam int unsigned N_BIT_DEFAULT    = 8;

endpackage : uart_rx_unit_pkg

// File: rtl/uart_rx_unit_baud_tick_gen.sv
// Free-running oversampling tick divider: one-cycle tick every DVSR clocks.
// Shared between the RX and TX units.
module baud_tick_gen
  import uart_rx_unit_pkg::*;
#(
  parameter int unsigned DVSR     = DVSR_DEFAULT,
  parameter int unsigned DVSR_BIT = DVSR_BIT_DEFAULT
) (
  input  logic CLK,
  input  logic RESET,
  output logic tick
);

  localparam logic [DVSR_BIT-1:0] CNT_LAST = DVSR_BIT'(DVSR - 1);

  logic [DVSR_BIT-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule : baud_tick_gen

// File: rtl/uart_rx_unit.sv
// UART 8N1 receiver: synchronizes rx, oversamples on baud ticks and emits one-cycle
// rx_done / frame_err strobes for the RX FIFO write port.
module uart_rx_unit
  import uart_rx_unit_pkg::*;
#(
  parameter int unsigned N_BIT    = N_BIT_DEFAULT,
  parameter int unsigned N_TICK   = N_TICK_DEFAULT,
  parameter int unsigned DVSR     = DVSR_DEFAULT,
  parameter int unsigned DVSR_BIT = DVSR_BIT_DEFAULT
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             rx,
  output logic [N_BIT-1:0] dout,
  output logic             rx_done,
  output logic             frame_err,
  output logic             busy
);

  localparam int unsigned S_W = $clog2(N_TICK);
  localparam int unsigned N_W = (N_BIT > 1) ? $clog2(N_BIT) : 1;

  localparam logic [S_W-1:0] S_MID  = S_W'(N_TICK / 2 - 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(N_TICK - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(N_BIT - 1);

  logic tick;

  baud_tick_gen #(
    .DVSR     (DVSR),
    .DVSR_BIT (DVSR_BIT)
  ) u_baud_tick_gen (
    .CLK   (CLK),
    .RESET (RESET),
    .tick  (tick)
  );

  logic             sync1_q, rxs_q;
  rx_state_e        state_q, state_d;
  logic [S_W-1:0]   s_q, s_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [N_BIT-1:0] b_q, b_d;
  logic [N_BIT-1:0] dout_q, dout_d;
  logic             rx_done_q, rx_done_d;
  logic             frame_err_q, frame_err_d;

  // Synchronizer resets to the idle level so release from reset never looks like a start bit.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx;
      rxs_q   <= sync1_q;
    end
  end

  // NOTE: every signal gets a default first, so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    n_d         = n_q;
    b_d         = b_q;
    dout_d      = dout_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == S_MID) begin
            if (!rxs_q) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            b_d = {rxs_q, b_q[N_BIT-1:1]};
            if (n_q == N_LAST) state_d = STOP;
            else               n_d     = n_q + 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            state_d = IDLE;
            if (rxs_q) begin
              dout_d    = b_q;
              rx_done_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      s_q         <= '0;
      n_q         <= '0;
      b_q         <= '0;
      dout_q      <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      n_q         <= n_d;
      b_q         <= b_d;
      dout_q      <= dout_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign dout      = dout_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule : uart_rx_unit

// File: tb/tb_uart_rx_unit.sv
// Self-checking bench for uart_rx_unit: drives 8N1 frames bit by bit and compares
// received words against the list of words it sent.
module tb_uart_rx_unit;

  localparam int DVSR   = 4;
  localparam int N_TICK = 16;
  localparam int BIT    = DVSR * N_TICK;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] dout;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  uart_rx_unit #(
    .N_BIT    (8),
    .N_TICK   (N_TICK),
    .DVSR     (DVSR),
    .DVSR_BIT (8)
  ) dut (
    .CLK       (clk),
    .RESET     (rst_n),
    .rx        (rx),
    .dout      (dout),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  // Observation side: everything the DUT reports, recorded between edges.
  logic [7:0] rx_q[$];
  int         ferr_cnt     = 0;
  logic [7:0] dout_at_ferr = 8'h00;
  int         done_cyc     = 0;
  int         start_cyc    = 0;
  bit         busy_seen    = 0;
  bit         prev_strobe  = 0;
  logic [7:0] last_good    = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_strobe = 0;
    end else begin
      if (busy) busy_seen = 1;
      if (rx_done) begin
        rx_q.push_back(dout);
        done_cyc = cyc;
      end
      if (frame_err) begin
        ferr_cnt++;
        dout_at_ferr = dout;
      end
      if (rx_done || frame_err) begin
        n_cmp++;
        if ((rx_done && frame_err) || prev_strobe) begin
          n_err++;
          $display("FAIL strobe_excl: rx_done=%0b frame_err=%0b prev_strobe=%0b, required one strobe with an idle cycle before",
                   rx_done, frame_err, prev_strobe);
        end
      end
      prev_strobe = rx_done || frame_err;
    end
  end

  task automatic hold_bit(input logic v, input int ncyc);
    rx = v;
    repeat (ncyc) @(negedge clk);
  endtask

  // Caller is at a negedge; stop_ok=0 drives the mid-stop sample low then releases the line.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok);
    start_cyc = cyc;
    hold_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold_bit(d[i], BIT);
    if (stop_ok) begin
      hold_bit(1'b1, BIT);
    end else begin
      hold_bit(1'b0, 40);
      hold_bit(1'b1, BIT - 40);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 4 * BIT) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      rx = $urandom_range(0, 1);
    end
    n_cmp += 4;
    if (dout !== 8'h00)    begin n_err++; $display("FAIL reset_dout: got %h, required 00", dout); end
    if (rx_done !== 1'b0)  begin n_err++; $display("FAIL reset_rx_done: got %b, required 0", rx_done); end
    if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
    if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b, required 0", busy); end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (5 * BIT) @(negedge clk);
    n_cmp += 2;
    if (rx_q.size() != 0) begin n_err++; $display("FAIL reset_idle_done: got %0d words, required 0", rx_q.size()); end
    if (ferr_cnt != 0)    begin n_err++; $display("FAIL reset_idle_ferr: got %0d, required 0", ferr_cnt); end
  endtask

  task automatic test_single();
    int f0 = ferr_cnt;
    int lat;
    int nominal = (19 * BIT) / 2 + 2;
    rx_q.delete();
    @(negedge clk);
    send_frame(8'hA5, 1);
    last_good = 8'hA5;
    wait_idle("single");
    lat = done_cyc - start_cyc;
    n_cmp += 5;
    if (rx_q.size() != 1) begin n_err++; $display("FAIL single_count: got %0d, required 1", rx_q.size()); end
    else if (rx_q[0] !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h, required a5", rx_q[0]); end
    if (dout !== 8'hA5) begin n_err++; $display("FAIL single_dout: got %h, required a5", dout); end
    if (ferr_cnt != f0) begin n_err++; $display("FAIL single_ferr: got %0d, required %0d", ferr_cnt, f0); end
    if (lat < nominal - DVSR || lat > nominal + 1 + DVSR) begin
      n_err++;
      $display("FAIL single_latency: got %0d cycles, required %0d..%0d", lat, nominal - DVSR, nominal + 1 + DVSR);
    end
  endtask

  task automatic run_stream(input string name, input logic [7:0] words[$], input int max_gap);
    int f0 = ferr_cnt;
    rx_q.delete();
    @(negedge clk);
    foreach (words[i]) begin
      send_frame(words[i], 1);
      if (max_gap > 0) hold_bit(1'b1, $urandom_range(0, max_gap));
    end
    if (words.size() > 0) last_good = words[words.size() - 1];
    wait_idle(name);
    n_cmp += 2;
    if (rx_q.size() != words.size()) begin
      n_err++;
      $display("FAIL %s_count: got %0d words, required %0d", name, rx_q.size(), words.size());
    end
    if (ferr_cnt != f0) begin n_err++; $display("FAIL %s_ferr: got %0d, required %0d", name, ferr_cnt, f0); end
    for (int i = 0; i < words.size() && i < rx_q.size(); i++) begin
      n_cmp++;
      if (rx_q[i] !== words[i]) begin
        n_err++;
        $display("FAIL %s_word%0d: got %h, required %h", name, i, rx_q[i], words[i]);
      end
    end
    n_cmp++;
    if (dout !== last_good) begin n_err++; $display("FAIL %s_dout: got %h, required %h", name, dout, last_good); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w[$];
    w = '{8'h00, 8'hFF, 8'h3C};
    run_stream("b2b", w, 0);
  endtask

  task automatic test_random();
    logic [7:0] w[$];
    for (int i = 0; i < 8; i++) w.push_back(8'($urandom));
    run_stream("random", w, 3 * DVSR);
  endtask

  task automatic test_glitch();
    int f0 = ferr_cnt;
    rx_q.delete();
    busy_seen = 0;
    @(negedge clk);
    hold_bit(1'b0, 20);
    hold_bit(1'b1, 2 * BIT);
    n_cmp += 4;
    if (busy_seen !== 1'b1) begin n_err++; $display("FAIL glitch_busy_pulse: got %b, required 1", busy_seen); end
    if (busy !== 1'b0)      begin n_err++; $display("FAIL glitch_busy_end: got %b, required 0", busy); end
    if (rx_q.size() != 0)   begin n_err++; $display("FAIL glitch_done: got %0d words, required 0", rx_q.size()); end
    if (ferr_cnt != f0)     begin n_err++; $display("FAIL glitch_ferr: got %0d, required %0d", ferr_cnt, f0); end
  endtask

  task automatic test_frame_error();
    int f0 = ferr_cnt;
    logic [7:0] w[$];
    rx_q.delete();
    @(negedge clk);
    send_frame(8'h55, 0);
    hold_bit(1'b1, 2 * BIT);
    wait_idle("ferr");
    n_cmp += 4;
    if (ferr_cnt != f0 + 1)       begin n_err++; $display("FAIL ferr_count: got %0d, required %0d", ferr_cnt, f0 + 1); end
    if (rx_q.size() != 0)         begin n_err++; $display("FAIL ferr_done: got %0d words, required 0", rx_q.size()); end
    if (dout_at_ferr !== last_good) begin n_err++; $display("FAIL ferr_dout_hold: got %h, required %h", dout_at_ferr, last_good); end
    if (dout !== last_good)       begin n_err++; $display("FAIL ferr_dout_after: got %h, required %h", dout, last_good); end
    w = '{8'h81};
    run_stream("after_ferr", w, 0);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d = 8'hC3;
    logic [7:0] w[$];
    rx_q.delete();
    @(negedge clk);
    hold_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) hold_bit(d[i], BIT);
    hold_bit(d[4], 30);
    rst_n = 1'b0;
    #1;
    n_cmp += 4;
    if (dout !== 8'h00)     begin n_err++; $display("FAIL midrst_dout: got %h, required 00", dout); end
    if (rx_done !== 1'b0)   begin n_err++; $display("FAIL midrst_rx_done: got %b, required 0", rx_done); end
    if (frame_err !== 1'b0) begin n_err++; $display("FAIL midrst_frame_err: got %b, required 0", frame_err); end
    if (busy !== 1'b0)      begin n_err++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_good = 8'h00;
    repeat (2 * BIT) @(negedge clk);
    n_cmp++;
    if (rx_q.size() != 0) begin n_err++; $display("FAIL midrst_no_strobe: got %0d words, required 0", rx_q.size()); end
    w = '{8'h12};
    run_stream("after_rst", w, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_random();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule : tb_uart_rx_unit
